// File: rtl/aes_pkg.sv
// Shared AES-128 definitions for the round-chain engines.
//   state_t : 16-byte block, element [r][c] holds FIPS byte 4c+r
//   NR      : number of AES-128 rounds
//   SBOX    : forward substitution table
//   xtime / gmul : GF(2^8) helpers, reduction polynomial 0x11B
//   fsm_e   : engine control states
package aes_pkg;

  typedef logic [3:0][3:0][7:0] state_t;

  localparam int unsigned NR = 10;

  typedef enum logic [1:0] {
    StIdle,
    StRound,
    StDone
  } fsm_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Shift-and-add multiply; MixColumns only needs factors 2 and 3.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

endpackage

// File: rtl/addroundkey.sv
// AddRoundKey: bytewise XOR of a block with a round key.
//   din  : input block
//   rkey : round key, same layout as din
//   dout : din XOR rkey
module addroundkey
  import aes_pkg::*;
(
  input  state_t din,
  input  state_t rkey,
  output state_t dout
);

  assign dout = din ^ rkey;

endmodule

// File: rtl/encround_comb.sv
// Combinational encrypt round body: SubBytes -> ShiftRows -> MixColumns.
//   din  : round input block
//   last : 1 bypasses MixColumns (final round)
//   dout : transformed block, round key not yet added
module encround_comb
  import aes_pkg::*;
(
  input  state_t din,
  input  logic   last,
  output state_t dout
);

  state_t sb;
  state_t sr;
  state_t mc;

  always_comb begin
    sb = '0;
    sr = '0;
    mc = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        sb[r][c] = SBOX[din[r][c]];
      end
    end
    // Row r rotates left by r: output column c takes input column c+r.
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        sr[r][c] = sb[r][(c + r) % 4];
      end
    end
    for (int c = 0; c < 4; c++) begin
      mc[0][c] = gmul(sr[0][c], 8'h02) ^ gmul(sr[1][c], 8'h03) ^ sr[2][c] ^ sr[3][c];
      mc[1][c] = sr[0][c] ^ gmul(sr[1][c], 8'h02) ^ gmul(sr[2][c], 8'h03) ^ sr[3][c];
      mc[2][c] = sr[0][c] ^ sr[1][c] ^ gmul(sr[2][c], 8'h02) ^ gmul(sr[3][c], 8'h03);
      mc[3][c] = gmul(sr[0][c], 8'h03) ^ sr[1][c] ^ sr[2][c] ^ gmul(sr[3][c], 8'h02);
    end
  end

  assign dout = last ? sr : mc;

endmodule

// File: rtl/encrypt_round_engine.sv
// Iterative AES-128 encryption, one round per clock.
//   clk, rst   : clock, synchronous active-high reset
//   start      : encrypt blockin (taken only while ready=1)
//   blockin    : plaintext
//   ready      : idle, start accepted
//   key_idx    : round key index required this cycle
//   key        : round key for key_idx, valid combinationally
//   blockout   : ciphertext, meaningful while out_valid=1
//   out_valid  : ciphertext held until out_ready
//   out_ready  : consumer accepts blockout
module encrypt_round_engine
  import aes_pkg::*;
#(
  parameter int unsigned NR = aes_pkg::NR
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  state_t       blockin,
  output logic         ready,
  output logic [3:0]   key_idx,
  input  state_t       key,
  output state_t       blockout,
  output logic         out_valid,
  input  logic         out_ready
);

  fsm_e       fsm_q, fsm_d;
  state_t     state_q, state_d;
  logic [3:0] round_q, round_d;

  logic   last_round;
  state_t round_out;
  state_t ark_in;
  state_t ark_out;

  assign last_round = (round_q == 4'(NR));

  encround_comb u_round (
    .din  (state_q),
    .last (last_round),
    .dout (round_out)
  );

  // One shared key adder: initial AddRoundKey in IDLE, round output otherwise.
  assign ark_in = (fsm_q == StIdle) ? blockin : round_out;

  addroundkey u_ark (
    .din  (ark_in),
    .rkey (key),
    .dout (ark_out)
  );

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    round_d = round_q;
    unique case (fsm_q)
      StIdle: begin
        if (start) begin
          state_d = ark_out;
          round_d = 4'd1;
          fsm_d   = StRound;
        end
      end
      StRound: begin
        state_d = ark_out;
        if (last_round) begin
          fsm_d = StDone;
        end else begin
          round_d = round_q + 4'd1;
        end
      end
      StDone: begin
        if (out_ready) fsm_d = StIdle;
      end
      default: fsm_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= StIdle;
      state_q <= '0;
      round_q <= 4'd0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      round_q <= round_d;
    end
  end

  assign ready     = (fsm_q == StIdle);
  assign out_valid = (fsm_q == StDone);
  assign key_idx   = (fsm_q == StRound) ? round_q : 4'd0;
  assign blockout  = state_q;

endmodule

// File: tb/tb_encrypt_round_engine.sv
// Directed bench for encrypt_round_engine using FIPS-197 vectors.
module tb_encrypt_round_engine;
  import aes_pkg::*;

  logic       clk;
  logic       rst;
  logic       start;
  state_t     blockin;
  logic       ready;
  logic [3:0] key_idx;
  state_t     key;
  state_t     blockout;
  logic       out_valid;
  logic       out_ready;
  int         keysel;

  int n_assert;
  int n_fail;

  localparam logic [127:0] PtC1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CtC1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PtB  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CtB  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] R1B  = 128'ha49c7ff2689f352b6b5bea43026a5049;
  localparam logic [127:0] PtX  = 128'hdeadbeef0123456789abcdeffedcba98;

  encrypt_round_engine dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .blockin   (blockin),
    .ready     (ready),
    .key_idx   (key_idx),
    .key       (key),
    .blockout  (blockout),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic state_t to_state(input logic [127:0] v);
    state_t s;
    for (int i = 0; i < 16; i++) s[i % 4][i / 4] = v[127 - 8 * i -: 8];
    return s;
  endfunction

  function automatic logic [127:0] from_state(input state_t s);
    logic [127:0] v;
    for (int i = 0; i < 16; i++) v[127 - 8 * i -: 8] = s[i % 4][i / 4];
    return v;
  endfunction

  // Published expanded key schedules: set 0 = App. C.1, set 1 = App. B.
  function automatic logic [127:0] round_key(input int sel, input logic [3:0] idx);
    if (sel == 0) begin
      case (idx)
        4'd0:    return 128'h000102030405060708090a0b0c0d0e0f;
        4'd1:    return 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
        4'd2:    return 128'hb692cf0b643dbdf1be9bc5006830b3fe;
        4'd3:    return 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
        4'd4:    return 128'h47f7f7bc95353e03f96c32bcfd058dfd;
        4'd5:    return 128'h3caaa3e8a99f9deb50f3af57adf622aa;
        4'd6:    return 128'h5e390f7df7a69296a7553dc10aa31f6b;
        4'd7:    return 128'h14f9701ae35fe28c440adf4d4ea9c026;
        4'd8:    return 128'h47438735a41c65b9e016baf4aebf7ad2;
        4'd9:    return 128'h549932d1f08557681093ed9cbe2c974e;
        4'd10:   return 128'h13111d7fe3944a17f307a78b4d2b30c5;
        default: return 128'h0;
      endcase
    end else begin
      case (idx)
        4'd0:    return 128'h2b7e151628aed2a6abf7158809cf4f3c;
        4'd1:    return 128'ha0fafe1788542cb123a339392a6c7605;
        4'd2:    return 128'hf2c295f27a96b9435935807a7359f67f;
        4'd3:    return 128'h3d80477d4716fe3e1e237e446d7a883b;
        4'd4:    return 128'hef44a541a8525b7fb671253bdb0bad00;
        4'd5:    return 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        4'd6:    return 128'h6d88a37a110b3efddbf98641ca0093fd;
        4'd7:    return 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        4'd8:    return 128'head27321b58dbad2312bf5607f8d292f;
        4'd9:    return 128'hac7766f319fadc2128d12941575c006e;
        4'd10:   return 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        default: return 128'h0;
      endcase
    end
  endfunction

  always_comb key = to_state(round_key(keysel, key_idx));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; sample and drive 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_assert  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    start     = 1'b0;
    out_ready = 1'b0;
    blockin   = '0;
    keysel    = 0;
    step();
    step();
    rst = 1'b0;

    chk("reset_ready", 128'(ready), 128'd1);
    chk("reset_out_valid", 128'(out_valid), 128'd0);
    chk("reset_key_idx", 128'(key_idx), 128'd0);
    chk("reset_blockout", from_state(blockout), 128'h0);

    // App. C.1 with key_idx walk.
    keysel  = 0;
    blockin = to_state(PtC1);
    start   = 1'b1;
    chk("c1_idle_key_idx", 128'(key_idx), 128'd0);
    step();
    start = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      chk("c1_round_key_idx", 128'(key_idx), 128'(i));
      chk("c1_round_busy", 128'({ready, out_valid}), 128'd0);
      step();
    end
    chk("c1_out_valid", 128'(out_valid), 128'd1);
    chk("c1_blockout", from_state(blockout), CtC1);
    chk("c1_done_key_idx", 128'(key_idx), 128'd0);
    chk("c1_done_ready", 128'(ready), 128'd0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("c1_ready_after", 128'(ready), 128'd1);
    chk("c1_valid_after", 128'(out_valid), 128'd0);

    // App. B with round-1 state check and backpressure.
    keysel  = 1;
    blockin = to_state(PtB);
    start   = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("b_round1_state", from_state(dut.state_q), R1B);
    for (int i = 2; i < 11; i++) step();
    chk("b_out_valid", 128'(out_valid), 128'd1);
    chk("b_blockout", from_state(blockout), CtB);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_out_valid", 128'(out_valid), 128'd1);
      chk("bp_blockout", from_state(blockout), CtB);
      chk("bp_ready", 128'(ready), 128'd0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_release_ready", 128'(ready), 128'd1);

    // Start pulses while busy (cycle 3 in ROUND, cycle 11 in DONE) are ignored.
    keysel  = 0;
    blockin = to_state(PtC1);
    start   = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    blockin = to_state(PtX);
    start   = 1'b1;
    step();
    start = 1'b0;
    for (int i = 4; i < 10; i++) step();
    chk("busy_c10_valid", 128'(out_valid), 128'd0);
    step();
    chk("busy_c11_valid", 128'(out_valid), 128'd1);
    chk("busy_c11_blockout", from_state(blockout), CtC1);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("busy_c12_valid", 128'(out_valid), 128'd1);
    chk("busy_c12_blockout", from_state(blockout), CtC1);
    chk("busy_c12_ready", 128'(ready), 128'd0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("busy_ready_after", 128'(ready), 128'd1);

    // Reset in cycle 5 discards the block; a fresh start still works.
    keysel  = 1;
    blockin = to_state(PtB);
    start   = 1'b1;
    step();
    start = 1'b0;
    for (int i = 1; i < 5; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid_ready", 128'(ready), 128'd1);
    chk("rst_mid_out_valid", 128'(out_valid), 128'd0);
    chk("rst_mid_key_idx", 128'(key_idx), 128'd0);
    chk("rst_mid_blockout", from_state(blockout), 128'h0);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 1; i < 11; i++) step();
    chk("rst_fresh_valid", 128'(out_valid), 128'd1);
    chk("rst_fresh_blockout", from_state(blockout), CtB);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/encrypt_round_engine.md
# encrypt_round_engine

Iterative AES-128 encryption engine: the encrypt-direction counterpart of the decrypt round chain. It accepts one 16-byte plaintext block and applies the initial AddRoundKey, nine full rounds, and the final round (no MixColumns), one round per clock. It fetches round keys from an external key store through a same-cycle index/key lookup. The ciphertext is held under a valid/ready handshake until consumed.

## Interface
Parameters:
- NR, 10, number of rounds (fixed for AES-128; no other value is supported)

Ports:
- clk  input  1  single clock; all state changes on the rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request to encrypt blockin; sampled only while ready=1
- blockin  input  8 x [3:0][3:0]  plaintext, element [r][c] = FIPS byte 4c+r
- ready  output  1  engine idle and able to accept start
- key_idx  output  4  round-key index currently required (0..10)
- key  input  8 x [3:0][3:0]  round key for key_idx, combinationally valid in the same cycle, same layout as blockin
- blockout  output  8 x [3:0][3:0]  ciphertext, valid while out_valid=1
- out_valid  output  1  blockout holds a finished ciphertext
- out_ready  input  1  consumer accepts blockout when out_valid=1

## Operation
- FSM states: IDLE, ROUND, DONE.
- **IDLE**
  - ready=1, key_idx=0.
  - On start=1: state_reg <= blockin XOR key, round <= 1, go to ROUND.
- **ROUND**
  - ready=0, key_idx=round.
  - If round<NR: state_reg <= AddRoundKey(MixColumns(ShiftRows(SubBytes(state_reg))), key), round <= round+1.
  - If round==NR: state_reg <= AddRoundKey(ShiftRows(SubBytes(state_reg)), key), go to DONE.
- **DONE**
  - out_valid=1, blockout=state_reg, key_idx=0, ready=0.
  - On out_ready=1, go to IDLE. blockout keeps its value until the next start, but is meaningful only while out_valid=1.
- **Ignored inputs:** start is ignored in ROUND and DONE; no queueing. out_ready is ignored outside DONE.
- **Arithmetic:**
  - ShiftRows: row r rotates left by r columns.
  - MixColumns: GF(2^8) with reduction polynomial 0x11B; xtime(b) = (b<<1) XOR (b[7] ? 0x1B : 0x00), 8-bit result.
  - round counter is 4 bits, range 1..10, never wraps.
- **Reset** (any state, including mid-ROUND): next state IDLE, round=0, state_reg=0. The partial result is discarded and no out_valid pulse occurs.

## Timing
- Reset values: ready=1, out_valid=0, key_idx=0, blockout=0.
- If start is sampled in cycle 0, then:
  - cycles 1..10 are in ROUND with key_idx=1..10;
  - out_valid=1 from cycle 11 onward.
- Latency is 11 cycles from start to out_valid.
- If out_ready=1 in the first DONE cycle, ready=1 in the following cycle.
- Minimum start-to-start spacing is 12 cycles.
- key must be stable and correct within the cycle for the current key_idx. The engine registers nothing on the key path.
- Any number of out_ready=0 cycles holds DONE with blockout stable.

## Structure
- Shared package `aes_pkg`:
  - state typedef (8-bit [3:0][3:0]);
  - forward S-box constant table (256 x 8);
  - NR;
  - xtime and gmul helper functions;
  - FSM state enum.
- Reuse the existing addroundkey module.
- One new sub-module is natural: `encround_comb`, the combinational SubBytes -> ShiftRows -> optional MixColumns path. It takes a `last` input that bypasses MixColumns.
- The FSM, counter and registers live in the top module.

## Test plan
- **FIPS-197 App. C.1:**
  - Stimulus: key 000102030405060708090a0b0c0d0e0f; bench drives expanded keys by key_idx; plaintext 00112233445566778899aabbccddeeff.
  - Required: blockout = 69c4e0d86a7b0430d8cdb78070b4c55a at cycle 11.
- **FIPS-197 App. B:**
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c; plaintext 3243f6a8885a308d313198a2e0370734.
  - Required: blockout = 3925841d02dc09fbdc118597196a0b32.
  - Also check state_reg after round 1 equals a49c7ff2689f352b6b5bea43026a5049.
- **Backpressure:**
  - Stimulus: hold out_ready=0 for 5 cycles after out_valid.
  - Required: blockout and out_valid stay stable and ready stays 0. Raising out_ready gives ready=1 on the next cycle.
- **Start while busy:**
  - Stimulus: pulse start with a different blockin in cycles 3 and 11.
  - Required: the result matches the first block only, and out_valid rises exactly at cycle 11.
- **Reset mid-operation:**
  - Stimulus: assert rst in cycle 5.
  - Required: the next cycle shows ready=1, out_valid=0, key_idx=0, blockout=0. A fresh start then produces the correct ciphertext 11 cycles later.
- **key_idx sequence:**
  - Check key_idx = 0 in IDLE, then 1,2,...,10 in consecutive ROUND cycles, then 0 in DONE.
